// File: rtl/mesh_stdio_line_arbiter_if.sv
// Bundle of the per-tile character streams, the shared sink port and the
// status outputs of mesh_stdio_line_arbiter.
// Optional: MESH_STDIO_TIMESTAMP_EN adds out_ts_o (line start timestamp).
interface mesh_stdio_line_arbiter_if #(
  parameter int N_SRC  = 4,
  parameter int CHAR_W = 8
);
  localparam int SRC_W = $clog2(N_SRC);

  logic [N_SRC-1:0]        char_valid_i;
  logic [N_SRC*CHAR_W-1:0] char_data_i;
  logic [N_SRC-1:0]        char_ready_o;
  logic                    out_valid_o;
  logic [CHAR_W-1:0]       out_data_o;
  logic [SRC_W-1:0]        out_src_o;
  logic                    out_last_o;
  logic                    out_ready_i;
  logic                    busy_o;
  logic [N_SRC-1:0]        overflow_o;
`ifdef MESH_STDIO_TIMESTAMP_EN
  logic [31:0]             out_ts_o;
`endif

  // Tiles and console sink side
  modport master (
`ifdef MESH_STDIO_TIMESTAMP_EN
    input  out_ts_o,
`endif
    output char_valid_i, char_data_i, out_ready_i,
    input  char_ready_o, out_valid_o, out_data_o, out_src_o, out_last_o,
    input  busy_o, overflow_o
  );

  // Arbiter side
  modport slave (
`ifdef MESH_STDIO_TIMESTAMP_EN
    output out_ts_o,
`endif
    input  char_valid_i, char_data_i, out_ready_i,
    output char_ready_o, out_valid_o, out_data_o, out_src_o, out_last_o,
    output busy_o, overflow_o
  );
endinterface

// File: rtl/mesh_stdio_line_arbiter.sv
// Per-tile stdout line buffering with round-robin, line-atomic forwarding to
// a single character sink. Lines from different tiles never interleave.
// Optional: MESH_STDIO_TIMESTAMP_EN adds a free-running cycle counter whose
// value at line start is presented on out_ts_o for the whole line.
module mesh_stdio_line_arbiter #(
  parameter int N_SRC      = 4,
  parameter int LINE_DEPTH = 64,
  parameter int CHAR_W     = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  mesh_stdio_line_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(LINE_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SRC_W = $clog2(N_SRC);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] DRAIN = 1'b1;

  localparam logic [CHAR_W-1:0] NL_CHAR = CHAR_W'(10);
  localparam logic [CNT_W-1:0]  FULL_OCC = CNT_W'(LINE_DEPTH);
  localparam logic [CNT_W-1:0]  LAST_OCC = CNT_W'(LINE_DEPTH - 1);

  // Entry layout: {eol, char}
  logic [CHAR_W:0]    mem      [N_SRC][LINE_DEPTH];
  logic [PTR_W-1:0]   wr_ptr   [N_SRC];
  logic [PTR_W-1:0]   rd_ptr   [N_SRC];
  logic [CNT_W-1:0]   occ      [N_SRC];
  logic [CNT_W-1:0]   line_cnt [N_SRC];
  logic [CHAR_W-1:0]  in_char  [N_SRC];
  logic [CHAR_W:0]    in_entry [N_SRC];

  logic [N_SRC-1:0]   ready;
  logic [N_SRC-1:0]   push;
  logic [N_SRC-1:0]   push_eol;
  logic [N_SRC-1:0]   push_ovf;
  logic [N_SRC-1:0]   eol_inc_q;
  logic [N_SRC-1:0]   pop;
  logic [N_SRC-1:0]   pop_eol;
  logic [N_SRC-1:0]   overflow_q;
  logic [N_SRC-1:0]   nonempty;

  logic [0:0]         state;
  logic [SRC_W-1:0]   sel;
  logic [SRC_W-1:0]   rr_ptr;
  logic [SRC_W-1:0]   winner;
  logic               any_line;
  logic [CHAR_W:0]    head;

  // Source-side accept, discard of NUL, and eol tagging (newline or fill)
  always_comb begin
    ready    = '0;
    push     = '0;
    push_eol = '0;
    push_ovf = '0;
    nonempty = '0;
    for (int unsigned s = 0; s < N_SRC; s++) begin
      logic nl, fill;
      in_char[s]  = bus.char_data_i[s*CHAR_W +: CHAR_W];
      nl          = (in_char[s] == NL_CHAR);
      fill        = (occ[s] == LAST_OCC);
      ready[s]    = (occ[s] != FULL_OCC) & ~rst_i;
      push[s]     = bus.char_valid_i[s] & ready[s] & (in_char[s] != '0);
      push_eol[s] = push[s] & (nl | fill);
      push_ovf[s] = push[s] & fill & ~nl;
      in_entry[s] = {nl | fill, in_char[s]};
      nonempty[s] = (occ[s] != '0);
    end
  end

  assign head    = mem[sel][rd_ptr[sel]];
  assign pop_eol = pop & {N_SRC{head[CHAR_W]}};

  // Sink side: only the selected FIFO is ever popped
  always_comb begin
    pop = '0;
    if (state == DRAIN && bus.out_ready_i) pop[sel] = 1'b1;
  end

  assign bus.char_ready_o = ready;
  assign bus.out_valid_o  = (state == DRAIN);
  assign bus.out_data_o   = (state == DRAIN) ? head[CHAR_W-1:0] : '0;
  assign bus.out_last_o   = (state == DRAIN) & head[CHAR_W];
  assign bus.out_src_o    = sel;
  assign bus.busy_o       = (state == DRAIN) | (|nonempty);
  assign bus.overflow_o   = overflow_q;

  // Round-robin search over sources with a complete line, starting at rr_ptr
  always_comb begin
    any_line = 1'b0;
    winner   = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      logic [SRC_W:0] idx;
      idx = {1'b0, rr_ptr} + (SRC_W+1)'(i);
      if (idx >= (SRC_W+1)'(N_SRC)) idx = idx - (SRC_W+1)'(N_SRC);
      if (!any_line && line_cnt[idx[SRC_W-1:0]] != '0) begin
        any_line = 1'b1;
        winner   = idx[SRC_W-1:0];
      end
    end
  end

  // Character storage; contents need no reset since pointers gate validity
  always_ff @(posedge clk_i) begin
    for (int unsigned s = 0; s < N_SRC; s++) begin
      if (push[s]) mem[s][wr_ptr[s]] <= in_entry[s];
    end
  end

  // FIFO pointers, occupancy, complete-line counts and sticky overflow.
  // Line completion reaches line_cnt one cycle after the eol push.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned s = 0; s < N_SRC; s++) begin
        wr_ptr[s]   <= '0;
        rd_ptr[s]   <= '0;
        occ[s]      <= '0;
        line_cnt[s] <= '0;
      end
      eol_inc_q  <= '0;
      overflow_q <= '0;
    end else begin
      for (int unsigned s = 0; s < N_SRC; s++) begin
        wr_ptr[s]   <= wr_ptr[s] + PTR_W'(push[s]);
        rd_ptr[s]   <= rd_ptr[s] + PTR_W'(pop[s]);
        occ[s]      <= occ[s] + CNT_W'(push[s]) - CNT_W'(pop[s]);
        line_cnt[s] <= line_cnt[s] + CNT_W'(eol_inc_q[s]) - CNT_W'(pop_eol[s]);
      end
      eol_inc_q  <= push_eol;
      overflow_q <= overflow_q | push_ovf;
    end
  end

  // Line-level FSM: pick a source in IDLE, stream its line in DRAIN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= IDLE;
      sel    <= '0;
      rr_ptr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_line) begin
            sel    <= winner;
            rr_ptr <= (winner == SRC_W'(N_SRC - 1)) ? '0 : winner + 1'b1;
            state  <= DRAIN;
          end
        end
        default: begin
          if (bus.out_ready_i && head[CHAR_W]) state <= IDLE;
        end
      endcase
    end
  end

`ifdef MESH_STDIO_TIMESTAMP_EN
  logic [31:0] ts_cnt;
  logic [31:0] ts_q;

  // Free-running cycle counter, sampled when a line is granted
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ts_cnt <= '0;
      ts_q   <= '0;
    end else begin
      ts_cnt <= ts_cnt + 32'd1;
      if (state == IDLE && any_line) ts_q <= ts_cnt;
    end
  end

  assign bus.out_ts_o = ts_q;
`endif
endmodule

// File: tb/tb_mesh_stdio_line_arbiter.sv
// Directed self-checking bench for mesh_stdio_line_arbiter (default build).
module tb_mesh_stdio_line_arbiter;
  localparam int N_SRC      = 4;
  localparam int LINE_DEPTH = 64;
  localparam int CHAR_W     = 8;

  logic clk = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk = ~clk;

  mesh_stdio_line_arbiter_if #(.N_SRC(N_SRC), .CHAR_W(CHAR_W)) bus ();

  mesh_stdio_line_arbiter #(
    .N_SRC(N_SRC),
    .LINE_DEPTH(LINE_DEPTH),
    .CHAR_W(CHAR_W)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_i),
    .bus(bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  logic [7:0] seq4 [6] = '{8'h61, 8'h00, 8'h62, 8'h00, 8'h00, 8'h0A};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_one(input int s, input logic [7:0] ch);
    bus.char_valid_i[s] = 1'b1;
    bus.char_data_i[s*CHAR_W +: CHAR_W] = ch;
    step();
    bus.char_valid_i[s] = 1'b0;
    bus.char_data_i[s*CHAR_W +: CHAR_W] = 8'h00;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (bus.out_valid_o !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    check({tag, "_valid"}, 32'(bus.out_valid_o), 32'd1);
  endtask

  // Sample one sink character and let the next edge consume it (out_ready_i=1)
  task automatic expect_char(input string tag, input logic [7:0] d, input int src, input logic last);
    wait_valid(tag);
    check({tag, "_data"}, 32'(bus.out_data_o), 32'(d));
    check({tag, "_src"},  32'(bus.out_src_o),  32'(src));
    check({tag, "_last"}, 32'(bus.out_last_o), 32'(last));
    step();
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    step();
    step();
    rst_i = 1'b0;
    step();
  endtask

  initial begin
    bus.char_valid_i = '0;
    bus.char_data_i  = '0;
    bus.out_ready_i  = 1'b1;

    // Reset state
    #1;
    check("rst_ready_low", 32'(bus.char_ready_o), 32'h0);
    step();
    step();
    check("rst_valid", 32'(bus.out_valid_o), 32'd0);
    check("rst_last",  32'(bus.out_last_o),  32'd0);
    check("rst_data",  32'(bus.out_data_o),  32'd0);
    check("rst_src",   32'(bus.out_src_o),   32'd0);
    check("rst_ovf",   32'(bus.overflow_o),  32'd0);
    check("rst_busy",  32'(bus.busy_o),      32'd0);
    rst_i = 1'b0;
    step();
    check("rst_ready_hi", 32'(bus.char_ready_o), 32'hF);

    // 1: "hi\n" from src1, latency two edges after the newline
    send_one(1, "h");
    send_one(1, "i");
    send_one(1, 8'h0A);
    check("t1_lat0", 32'(bus.out_valid_o), 32'd0);
    step();
    check("t1_lat1", 32'(bus.out_valid_o), 32'd0);
    step();
    check("t1_lat2", 32'(bus.out_valid_o), 32'd1);
    expect_char("t1_h",  "h",   1, 1'b0);
    expect_char("t1_i",  "i",   1, 1'b0);
    expect_char("t1_nl", 8'h0A, 1, 1'b1);
    check("t1_idle", 32'(bus.out_valid_o), 32'd0);
    check("t1_busy", 32'(bus.busy_o),      32'd0);

    // 2: all four sources at once from rr_ptr=0
    do_reset();
    bus.char_valid_i = 4'hF;
    bus.char_data_i  = {4{8'h41}};
    step();
    bus.char_data_i  = {4{8'h0A}};
    step();
    bus.char_valid_i = '0;
    bus.char_data_i  = '0;
    for (int s = 0; s < N_SRC; s++) begin
      expect_char($sformatf("t2_A%0d", s),  8'h41, s, 1'b0);
      expect_char($sformatf("t2_nl%0d", s), 8'h0A, s, 1'b1);
      check($sformatf("t2_bubble%0d", s), 32'(bus.out_valid_o), 32'd0);
    end
    // pointer wrapped to 0: src0 beats src2
    bus.char_valid_i = 4'b0101;
    bus.char_data_i  = {8'h00, 8'h42, 8'h00, 8'h42};
    step();
    bus.char_data_i  = {8'h00, 8'h0A, 8'h00, 8'h0A};
    step();
    bus.char_valid_i = '0;
    bus.char_data_i  = '0;
    expect_char("t2_wrapB0",  8'h42, 0, 1'b0);
    expect_char("t2_wrapNL0", 8'h0A, 0, 1'b1);
    expect_char("t2_wrapB2",  8'h42, 2, 1'b0);
    expect_char("t2_wrapNL2", 8'h0A, 2, 1'b1);

    // 3: 64 chars with no newline fill src2 and force-terminate the line
    bus.out_ready_i = 1'b0;
    bus.char_valid_i[2] = 1'b1;
    bus.char_data_i[2*CHAR_W +: CHAR_W] = 8'h41;
    repeat (LINE_DEPTH) step();
    bus.char_valid_i = '0;
    bus.char_data_i  = '0;
    check("t3_full_rdy", 32'(bus.char_ready_o[2]), 32'd0);
    check("t3_ovf",      32'(bus.overflow_o),      32'h4);
    step();
    step();
    check("t3_hold_rdy", 32'(bus.char_ready_o[2]), 32'd0);
    check("t3_valid",    32'(bus.out_valid_o),     32'd1);
    bus.out_ready_i = 1'b1;
    for (int i = 0; i < LINE_DEPTH; i++)
      expect_char($sformatf("t3_c%0d", i), 8'h41, 2, (i == LINE_DEPTH - 1));
    check("t3_ovf_sticky", 32'(bus.overflow_o),      32'h4);
    check("t3_rdy_back",   32'(bus.char_ready_o[2]), 32'd1);

    // 4: NUL bytes are accepted and dropped
    for (int i = 0; i < 6; i++) begin
      check($sformatf("t4_rdy%0d", i), 32'(bus.char_ready_o[0]), 32'd1);
      send_one(0, seq4[i]);
    end
    expect_char("t4_a",  "a",   0, 1'b0);
    expect_char("t4_b",  "b",   0, 1'b0);
    expect_char("t4_nl", 8'h0A, 0, 1'b1);
    check("t4_no_extra", 32'(bus.out_valid_o), 32'd0);
    check("t4_busy",     32'(bus.busy_o),      32'd0);

    // 5: sink stall holds the head character
    bus.out_ready_i = 1'b0;
    send_one(1, "p");
    send_one(1, "q");
    send_one(1, 8'h0A);
    wait_valid("t5_first");
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("t5_v%0d", i), 32'(bus.out_valid_o), 32'd1);
      check($sformatf("t5_d%0d", i), 32'(bus.out_data_o),  32'h70);
    end
    bus.out_ready_i = 1'b1;
    expect_char("t5_p",  "p",   1, 1'b0);
    expect_char("t5_q",  "q",   1, 1'b0);
    expect_char("t5_nl", 8'h0A, 1, 1'b1);
    check("t5_idle", 32'(bus.out_valid_o), 32'd0);

    // 6: reset in the middle of a src3 line
    bus.out_ready_i = 1'b0;
    send_one(3, "z");
    send_one(3, "z");
    send_one(3, 8'h0A);
    send_one(1, "k");
    wait_valid("t6_drain");
    check("t6_src", 32'(bus.out_src_o), 32'd3);
    bus.out_ready_i = 1'b1;
    expect_char("t6_z0", "z", 3, 1'b0);
    bus.out_ready_i = 1'b0;
    check("t6_ovf_pre", 32'(bus.overflow_o), 32'h4);
    rst_i = 1'b1;
    step();
    check("t6_valid", 32'(bus.out_valid_o),  32'd0);
    check("t6_last",  32'(bus.out_last_o),   32'd0);
    check("t6_busy",  32'(bus.busy_o),       32'd0);
    check("t6_ovf",   32'(bus.overflow_o),   32'd0);
    check("t6_rdy",   32'(bus.char_ready_o), 32'h0);
    rst_i = 1'b0;
    step();
    check("t6_rdy_hi", 32'(bus.char_ready_o), 32'hF);
    bus.out_ready_i = 1'b1;
    // rr_ptr is back at 0, so src0 precedes src2
    bus.char_valid_i = 4'b0101;
    bus.char_data_i  = {8'h00, 8'h79, 8'h00, 8'h78};
    step();
    bus.char_data_i  = {8'h00, 8'h0A, 8'h00, 8'h0A};
    step();
    bus.char_valid_i = '0;
    bus.char_data_i  = '0;
    expect_char("t6_x",   "x",   0, 1'b0);
    expect_char("t6_nl0", 8'h0A, 0, 1'b1);
    expect_char("t6_y",   "y",   2, 1'b0);
    expect_char("t6_nl2", 8'h0A, 2, 1'b1);
    check("t6_end_valid", 32'(bus.out_valid_o), 32'd0);
    check("t6_end_busy",  32'(bus.busy_o),      32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
